player_bullet_controller: RTL and testbench

//  Producer side of the 8-slot player-bullet bus read by the enemy controllers.

---
 rtl/game_pkg.sv | 22 ++
 rtl/fire_debounce_edge.sv | 50 +++++
 rtl/player_bullet_controller.sv | 103 ++++++++++
 tb/tb_player_bullet_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants and flat-bus helpers used by the player and enemy
// controllers.
`timescale 1ns/1ps
package game_pkg;

    localparam int MAX_BULLETS = 8;
    localparam int COORD_W     = 10;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int BULLET_W    = 8;
    localparam int BULLET_H    = 8;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic coord_t slot_coord(
        input logic [MAX_BULLETS*COORD_W-1:0] flat,
        input int                            j
    );
        return flat[j*COORD_W +: COORD_W];
    endfunction

endpackage

// File: rtl/fire_debounce_edge.sv
// Fire button synchronizer, rising-edge detector and shot cooldown.
// shot_req is a single-cycle accepted-shot strobe.
`timescale 1ns/1ps
module fire_debounce_edge #(
    parameter int COOLDOWN = 2_500_000
) (
    input  logic clk25,
    input  logic rst_n,
    input  logic fire_btn,
    output logic shot_req
);

    localparam int CW = $clog2(COOLDOWN + 1);

    logic          s1;
    logic          s2;
    logic          s2_d;
    logic          v1;
    logic          v2;
    logic          armed;
    logic [CW-1:0] cool;

    // armed: a real released level has been seen since reset, so a
    // button held through reset cannot fire.
    assign shot_req = armed & s2 & ~s2_d & (cool == '0);

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s2_d  <= 1'b0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            armed <= 1'b0;
            cool  <= '0;
        end else begin
            s1    <= fire_btn;
            s2    <= s1;
            s2_d  <= s2;
            v1    <= 1'b1;
            v2    <= v1;
            armed <= armed | (v2 & ~s2);
            if (shot_req)
                cool <= CW'(COOLDOWN - 1);
            else if (cool != '0)
                cool <= cool - 1'b1;
        end
    end

endmodule

// File: rtl/player_bullet_controller.sv
// Player bullet producer: spawns bullets on fire, moves them upward and
// retires them at the top edge or on an enemy-reported hit.
`timescale 1ns/1ps
module player_bullet_controller
    import game_pkg::*;
#(
    parameter int MOVE_PERIOD = 500_000,
    parameter int SPEED       = 4,
    parameter int COOLDOWN    = 2_500_000,
    parameter int SPAWN_DX    = 12,
    parameter int SPAWN_DY    = 8
) (
    input  logic                           clk25,
    input  logic                           rst_n,
    input  logic                           fire_btn,
    input  logic [COORD_W-1:0]             player_x,
    input  logic [COORD_W-1:0]             player_y,
    input  logic [MAX_BULLETS-1:0]         bullet_hit_flat,
    output logic [MAX_BULLETS*COORD_W-1:0] bullet_x_flat,
    output logic [MAX_BULLETS*COORD_W-1:0] bullet_y_flat,
    output logic [MAX_BULLETS-1:0]         bullet_active_flat
);

    localparam int TW = $clog2(MOVE_PERIOD);

    logic                   shot_req;
    logic                   tick;
    logic [TW-1:0]          tick_cnt;
    logic [MAX_BULLETS-1:0] free;
    logic [MAX_BULLETS-1:0] spawn;
    logic [COORD_W-1:0]     spawn_x;
    logic [COORD_W-1:0]     spawn_y;
    logic                   spawn_ok;

    fire_debounce_edge #(
        .COOLDOWN(COOLDOWN)
    ) u_fire (
        .clk25   (clk25),
        .rst_n   (rst_n),
        .fire_btn(fire_btn),
        .shot_req(shot_req)
    );

    assign tick = (tick_cnt == TW'(MOVE_PERIOD - 1));

    always_ff @(posedge clk25) begin
        if (!rst_n)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    assign spawn_x  = player_x + COORD_W'(SPAWN_DX);
    assign spawn_y  = player_y - COORD_W'(SPAWN_DY);
    assign spawn_ok = shot_req && (player_y >= COORD_W'(SPAWN_DY));

    // Lowest free slot wins; a slot hit this cycle counts as free.
    always_comb begin
        spawn = '0;
        if (spawn_ok) begin
            for (int j = MAX_BULLETS - 1; j >= 0; j--) begin
                if (free[j]) begin
                    spawn    = '0;
                    spawn[j] = 1'b1;
                end
            end
        end
    end

    for (genvar j = 0; j < MAX_BULLETS; j++) begin : gen_slot
        logic               act_q;
        logic [COORD_W-1:0] x_q;
        logic [COORD_W-1:0] y_q;

        assign free[j] = ~act_q | bullet_hit_flat[j];
        assign bullet_active_flat[j]             = act_q;
        assign bullet_x_flat[j*COORD_W +: COORD_W] = x_q;
        assign bullet_y_flat[j*COORD_W +: COORD_W] = y_q;

        always_ff @(posedge clk25) begin
            if (!rst_n) begin
                act_q <= 1'b0;
                x_q   <= '0;
                y_q   <= '0;
            end else if (spawn[j]) begin
                act_q <= 1'b1;
                x_q   <= spawn_x;
                y_q   <= spawn_y;
            end else if (bullet_hit_flat[j]) begin
                act_q <= 1'b0;
            end else if (tick && act_q) begin
                // Retire at the top edge instead of wrapping below zero.
                if (y_q >= COORD_W'(SPEED))
                    y_q <= y_q - COORD_W'(SPEED);
                else
                    act_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_player_bullet_controller.sv
// Scoreboard bench for player_bullet_controller with a bullet-list model.
`timescale 1ns/1ps
module tb_player_bullet_controller;
    import game_pkg::*;

    localparam int MP = 4;
    localparam int SP = 4;
    localparam int CD = 8;
    localparam int DX = 12;
    localparam int DY = 8;

    logic        clk25 = 1'b0;
    logic        rst_n = 1'b0;
    logic        fire_btn = 1'b0;
    logic [9:0]  player_x = '0;
    logic [9:0]  player_y = '0;
    logic [7:0]  bullet_hit_flat = '0;
    logic [79:0] bullet_x_flat;
    logic [79:0] bullet_y_flat;
    logic [7:0]  bullet_active_flat;

    player_bullet_controller #(
        .MOVE_PERIOD(MP),
        .SPEED      (SP),
        .COOLDOWN   (CD),
        .SPAWN_DX   (DX),
        .SPAWN_DY   (DY)
    ) dut (
        .clk25             (clk25),
        .rst_n             (rst_n),
        .fire_btn          (fire_btn),
        .player_x          (player_x),
        .player_y          (player_y),
        .bullet_hit_flat   (bullet_hit_flat),
        .bullet_x_flat     (bullet_x_flat),
        .bullet_y_flat     (bullet_y_flat),
        .bullet_active_flat(bullet_active_flat)
    );

    always #20 clk25 = ~clk25;

    typedef struct packed {
        logic [7:0]  act;
        logic [79:0] x;
        logic [79:0] y;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Model: cycles since reset release, raw button history, bullet list.
    int m = -1;
    bit hist[$];
    int last_shot = -1000000;
    bit m_act[8];
    int m_x[8];
    int m_y[8];

    task automatic step(input bit r, input bit b, input int px,
                        input int py, input bit [7:0] h);
        exp_t e;
        bit   shot;
        int   slot;
        @(negedge clk25);
        #1;
        rst_n           = r;
        fire_btn        = b;
        player_x        = 10'(px);
        player_y        = 10'(py);
        bullet_hit_flat = h;
        if (!r) begin
            m = -1;
            hist.delete();
            last_shot = -1000000;
            for (int j = 0; j < 8; j++) begin
                m_act[j] = 0;
                m_x[j]   = 0;
                m_y[j]   = 0;
            end
        end else begin
            m++;
            hist.push_back(b);
            shot = (m >= 3) && hist[m-2] && !hist[m-3] &&
                   (m - last_shot >= CD);
            if (shot)
                last_shot = m;
            slot = -1;
            for (int j = 0; j < 8; j++)
                if (slot < 0 && (!m_act[j] || h[j]))
                    slot = j;
            for (int j = 0; j < 8; j++) begin
                if (h[j])
                    m_act[j] = 0;
                else if (m % MP == MP - 1 && m_act[j]) begin
                    if (m_y[j] >= SP)
                        m_y[j] -= SP;
                    else
                        m_act[j] = 0;
                end
            end
            if (shot && py >= DY && slot >= 0) begin
                m_act[slot] = 1;
                m_x[slot]   = (px + DX) % 1024;
                m_y[slot]   = py - DY;
            end
        end
        for (int j = 0; j < 8; j++) begin
            e.act[j]         = m_act[j];
            e.x[j*10 +: 10]  = 10'(m_x[j]);
            e.y[j*10 +: 10]  = 10'(m_y[j]);
        end
        q.push_back(e);
    endtask

    always @(negedge clk25) begin
        cyc++;
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            checks++;
            if (bullet_active_flat !== mon_e.act ||
                bullet_x_flat !== mon_e.x ||
                bullet_y_flat !== mon_e.y) begin
                errors++;
                $display("FAIL outputs cyc=%0d act=%h exp=%h x=%h exp=%h y=%h exp=%h s0y=%0d exp=%0d",
                         cyc, bullet_active_flat, mon_e.act,
                         bullet_x_flat, mon_e.x, bullet_y_flat, mon_e.y,
                         slot_coord(bullet_y_flat, 0), slot_coord(mon_e.y, 0));
            end
        end
    end

    task automatic idle(input int n, input int px, input int py);
        repeat (n) step(1, 0, px, py, 8'h00);
    endtask

    task automatic fire(input int px, input int py);
        step(1, 1, px, py, 8'h00);
        step(1, 0, px, py, 8'h00);
    endtask

    initial begin
        bit b;
        int px;
        int py;
        // Button held through reset must not fire.
        repeat (2) step(0, 1, 100, 400, 8'h00);
        repeat (20) step(1, 1, 100, 400, 8'h00);
        idle(3, 100, 400);
        fire(100, 400);
        idle(14, 100, 400);
        // Held button, then cooldown spacing.
        repeat (50) step(1, 1, 100, 400, 8'h00);
        idle(10, 100, 400);
        fire(200, 300);
        idle(2, 200, 300);
        fire(200, 300);
        idle(12, 200, 300);
        fire(300, 300);
        idle(7, 300, 300);
        fire(310, 300);
        idle(10, 300, 300);
        // Fill all slots, overflow, then free slot 3 and refill.
        step(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            fire(50 + i * 20, 450);
            idle(8, 50 + i * 20, 450);
        end
        step(1, 0, 0, 450, 8'h08);
        idle(3, 0, 450);
        fire(1020, 450);
        idle(10, 1020, 450);
        // Top-edge retire without wrap, and too-low player.
        step(0, 0, 0, 0, 8'h00);
        idle(4, 40, 14);
        fire(40, 14);
        idle(15, 40, 14);
        fire(40, 5);
        idle(10, 40, 5);
        // Hit on a tick cycle, then reset mid-flight.
        fire(60, 200);
        idle(4, 60, 200);
        while ((m + 1) % MP != MP - 1)
            idle(1, 60, 200);
        step(1, 0, 60, 200, 8'h01);
        idle(3, 60, 200);
        for (int i = 0; i < 5; i++) begin
            fire(60 + i, 200);
            idle(8, 60, 200);
        end
        step(0, 0, 60, 200, 8'h00);
        idle(5, 60, 200);
        // Randomized traffic.
        b  = 0;
        px = 100;
        py = 400;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0)
                b = !b;
            if ($urandom_range(0, 15) == 0)
                px = $urandom_range(0, 1023);
            if ($urandom_range(0, 15) == 0)
                py = ($urandom_range(0, 3) == 0) ?
                     $urandom_range(0, 20) : $urandom_range(0, 479);
            step($urandom_range(0, 699) != 0, b, px, py,
                 ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00);
        end
        repeat (3) @(negedge clk25);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
